avg_threshold_detector: RTL and testbench
=========================================

Name: avg_threshold_detector

Overview:
- Downstream consumer of the moving-average stage. Takes the 8-bit averaged value and its strobe, and applies high/low thresholds with hysteresis.
- Debounces threshold crossings over CONFIRM consecutive strobed samples.
- Drives a level alarm, one-cycle rise/fall event pulses, a saturating event counter and a per-episode peak value.
- Feeds the status/readout logic of the tile.

Parameters:
WIDTH, 8, bit width of averaged sample and thresholds
CONFIRM, 3, consecutive qualifying strobed samples needed to enter or leave alarm; legal range 1..15
CNT_W, 8, width of event counter

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
avg_in  input  WIDTH  averaged sample from moving-average stage
avg_valid  input  1  sample strobe; avg_in is consumed only in cycles where avg_valid=1
thr_hi  input  WIDTH  upper threshold; a sample qualifies "high" when avg_in > thr_hi
thr_lo  input  WIDTH  lower threshold; a sample qualifies "low" when avg_in < thr_lo
clear  input  1  synchronous clear of FSM, counter and peak
alarm  output  1  registered alarm level
rise_pulse  output  1  one-cycle pulse on alarm 0->1
fall_pulse  output  1  one-cycle pulse on alarm 1->0
event_count  output  CNT_W  number of alarm rises, saturating
peak  output  WIDTH  max avg_in accepted during the current/last alarm episode
cfg_err  output  1  registered, high while thr_lo > thr_hi

Behaviour:
- Reset (rst_n=0, async): state=IDLE, run counter=0, alarm=0, rise_pulse=0, fall_pulse=0, event_count=0, peak=0, cfg_err=0. Outputs stay at these values until the first rising edge after release.
- All outputs are registered. cfg_err updates every cycle from the current thresholds.
- FSM states: IDLE, ARMING, ALARM, RELEASING. Only cycles with avg_valid=1 advance the FSM; non-strobe cycles hold all state.
- IDLE, high sample: if CONFIRM=1 go to ALARM; else go to ARMING with cnt=1. Any other sample: stay in IDLE.
- ARMING, high sample: cnt+1. When cnt reaches CONFIRM, go to ALARM. Non-high sample: cnt=0, go to IDLE.
- ALARM, low sample: if CONFIRM=1 go to IDLE; else go to RELEASING with cnt=1. Any other sample: stay in ALARM.
- RELEASING, low sample: cnt+1. When cnt reaches CONFIRM, go to IDLE. Non-low sample: cnt=0, go back to ALARM.
- alarm=1 in states ALARM and RELEASING, else 0. It changes on the edge that registers the state transition, i.e. one clock after the confirming strobe cycle.
- rise_pulse and fall_pulse are high for exactly the first cycle of the new alarm level. They are never both high.
- event_count increments on each rise and saturates at 2^CNT_W-1 (no wrap).
- peak:
  - Loaded with avg_in of the confirming sample on entry to ALARM.
  - In ALARM/RELEASING, peak=max(peak, avg_in) on each strobe.
  - Holds its value after alarm falls, until the next rise or clear.
- Hysteresis band: samples with thr_lo <= avg_in <= thr_hi are neither high nor low. Equality with either threshold never qualifies.
- While thr_lo > thr_hi (cfg_err=1), strobed samples are ignored: FSM, cnt and peak hold.
- clear=1: next edge forces IDLE, cnt=0, alarm=0, event_count=0, peak=0. No fall_pulse is emitted. clear has priority over a simultaneous avg_valid.
- Reset mid-episode drops alarm immediately (async) with no fall_pulse.

Test Plan:
- CONFIRM=3, thr_hi=0x80, thr_lo=0x40; strobe 0xAA three times (every other cycle) -> alarm=1 and rise_pulse=1 for one cycle, one clock after the 3rd strobe; event_count=1, peak=0xAA.
- Same config; strobe 0xAA, 0xAA, 0x80, 0xAA, 0xAA -> no alarm (0x80 is not >thr_hi and resets cnt); the 3rd consecutive 0xAA later raises alarm.
- In alarm, strobe 0xFF, 0x55, 0x00, 0x00, 0x00 -> peak=0xFF; 0x55 lies in the band, so no release; alarm falls with fall_pulse one clock after the 3rd 0x00; peak stays 0xFF.
- Samples 0xFF presented with avg_valid=0 for 10 cycles -> no state change, alarm=0, event_count=0.
- Set thr_lo=0x90, thr_hi=0x80, strobe 0xFF x5 -> cfg_err=1, alarm stays 0. Restore thr_lo=0x40 -> cfg_err clears the next cycle.
- Drive 256 rise/fall episodes with CNT_W=8 -> event_count saturates at 0xFF. Assert clear during ALARM with avg_valid=1 -> alarm=0, count=0, peak=0, no fall_pulse. Pulse rst_n low mid-ARMING -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/avg_threshold_detector.sv
// Threshold detector with hysteresis on a strobed averaged sample. Crossings are debounced over
// CONFIRM consecutive strobes; drives alarm level, edge pulses, a saturating rise counter and peak.
module avg_threshold_detector #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CONFIRM = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] avg_in,
  input  logic             avg_valid,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  input  logic             clear,
  output logic             alarm,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_count,
  output logic [WIDTH-1:0] peak,
  output logic             cfg_err
);

  typedef enum logic [1:0] {StIdle, StArming, StAlarm, StReleasing} state_e;

  localparam logic [3:0]       ConfirmCnt = 4'(CONFIRM);
  localparam logic [CNT_W-1:0] CountMax   = '1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d, cnt_inc;
  logic             cnt_done;
  logic             cfg_bad, accept, is_hi, is_lo;
  logic             alarm_d;
  logic [WIDTH-1:0] peak_d, peak_max;
  logic [CNT_W-1:0] count_d;

  // Inverted thresholds disable sample qualification using the live threshold values.
  assign cfg_bad  = thr_lo > thr_hi;
  assign accept   = avg_valid && !cfg_bad;
  assign is_hi    = avg_in > thr_hi;
  assign is_lo    = avg_in < thr_lo;
  assign cnt_inc  = cnt_q + 4'd1;
  assign cnt_done = (cnt_inc == ConfirmCnt);
  assign peak_max = (avg_in > peak) ? avg_in : peak;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak;
    count_d = event_count;
    if (clear) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      peak_d  = '0;
      count_d = '0;
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (is_hi) begin
            if (ConfirmCnt == 4'd1) begin
              state_d = StAlarm;
              peak_d  = avg_in;
            end else begin
              state_d = StArming;
              cnt_d   = 4'd1;
            end
          end
        end
        StArming: begin
          if (is_hi) begin
            if (cnt_done) begin
              state_d = StAlarm;
              cnt_d   = 4'd0;
              peak_d  = avg_in;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end
        end
        StAlarm: begin
          peak_d = peak_max;
          if (is_lo) begin
            if (ConfirmCnt == 4'd1) begin
              state_d = StIdle;
            end else begin
              state_d = StReleasing;
              cnt_d   = 4'd1;
            end
          end
        end
        StReleasing: begin
          peak_d = peak_max;
          if (is_lo) begin
            if (cnt_done) begin
              state_d = StIdle;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StAlarm;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
    alarm_d = (state_d == StAlarm) || (state_d == StReleasing);
    if (!clear && alarm_d && !alarm && (event_count != CountMax)) begin
      count_d = event_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      alarm       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      event_count <= '0;
      peak        <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alarm       <= alarm_d;
      rise_pulse  <= alarm_d && !alarm;
      // A clear-forced drop is silent.
      fall_pulse  <= !alarm_d && alarm && !clear;
      event_count <= count_d;
      peak        <= peak_d;
      cfg_err     <= cfg_bad;
    end
  end

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Self-checking bench for avg_threshold_detector: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_avg_threshold_detector;

  localparam int CONFIRM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] avg_in = '0;
  logic       avg_valid = 1'b0;
  logic [7:0] thr_hi = 8'h80;
  logic [7:0] thr_lo = 8'h40;
  logic       clear = 1'b0;
  logic       alarm, rise_pulse, fall_pulse, cfg_err;
  logic [7:0] event_count, peak;

  int checks = 0;
  int errors = 0;

  avg_threshold_detector #(.WIDTH(8), .CONFIRM(CONFIRM), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .avg_in     (avg_in),
    .avg_valid  (avg_valid),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .clear      (clear),
    .alarm      (alarm),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_count(event_count),
    .peak       (peak),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // Model: count consecutive qualifying accepted samples toward the opposite alarm level.
  typedef struct {
    bit       alarm;
    bit       rise;
    bit       fall;
    int       run;
    int       count;
    int       peak;
    bit       cfg_err;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.alarm = 0; r.rise = 0; r.fall = 0; r.run = 0;
    r.count = 0; r.peak = 0; r.cfg_err = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t cur, bit v, int d, int hi, int lo, bit clr);
    model_t n = cur;
    n.rise    = 0;
    n.fall    = 0;
    n.cfg_err = (lo > hi);
    if (clr) begin
      n.alarm = 0; n.run = 0; n.count = 0; n.peak = 0;
    end else if (v && !(lo > hi)) begin
      if (!cur.alarm) begin
        n.run = (d > hi) ? cur.run + 1 : 0;
        if (n.run == CONFIRM) begin
          n.alarm = 1; n.rise = 1; n.run = 0; n.peak = d;
          n.count = (cur.count < 255) ? cur.count + 1 : 255;
        end
      end else begin
        n.peak = (d > cur.peak) ? d : cur.peak;
        n.run  = (d < lo) ? cur.run + 1 : 0;
        if (n.run == CONFIRM) begin
          n.alarm = 0; n.fall = 1; n.run = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_next(m, avg_valid, int'(avg_in), int'(thr_hi), int'(thr_lo), clear);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model.alarm", int'(alarm), int'(m.alarm));
      chk("model.rise", int'(rise_pulse), int'(m.rise));
      chk("model.fall", int'(fall_pulse), int'(m.fall));
      chk("model.count", int'(event_count), m.count);
      chk("model.peak", int'(peak), m.peak);
      chk("model.cfg_err", int'(cfg_err), int'(m.cfg_err));
      if (rise_pulse && fall_pulse) chk("rise_and_fall", 1, 0);
    end
  end

  // Strobe one sample then idle a cycle; outputs afterwards reflect that strobe.
  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    avg_valid = 1'b1;
    avg_in    = d;
    @(negedge clk);
    avg_valid = 1'b0;
  endtask

  task automatic episode();
    repeat (3) strobe(8'hAA);
    repeat (3) strobe(8'h00);
  endtask

  initial begin
    #1;
    chk("reset.alarm", int'(alarm), 0);
    chk("reset.count", int'(event_count), 0);
    chk("reset.peak", int'(peak), 0);
    chk("reset.pulses", int'({rise_pulse, fall_pulse, cfg_err}), 0);
    #20 rst_n = 1'b1;

    // Unstrobed high samples must be ignored.
    @(negedge clk);
    avg_in = 8'hFF;
    repeat (10) @(negedge clk);
    chk("nostrobe.alarm", int'(alarm), 0);
    chk("nostrobe.count", int'(event_count), 0);

    // Three high strobes raise alarm.
    strobe(8'hAA);
    strobe(8'hAA);
    chk("arm2.alarm", int'(alarm), 0);
    strobe(8'hAA);
    chk("rise.alarm", int'(alarm), 1);
    chk("rise.pulse", int'(rise_pulse), 1);
    chk("rise.count", int'(event_count), 1);
    chk("rise.peak", int'(peak), 8'hAA);
    @(negedge clk);
    chk("rise.pulse_once", int'(rise_pulse), 0);

    // Peak tracking, band sample does not release, three lows release.
    strobe(8'hFF);
    chk("peak.ff", int'(peak), 8'hFF);
    strobe(8'h55);
    chk("band.alarm", int'(alarm), 1);
    strobe(8'h00);
    strobe(8'h00);
    chk("rel2.alarm", int'(alarm), 1);
    strobe(8'h00);
    chk("fall.alarm", int'(alarm), 0);
    chk("fall.pulse", int'(fall_pulse), 1);
    chk("fall.peak_hold", int'(peak), 8'hFF);

    // Threshold equality breaks the run.
    strobe(8'hAA);
    strobe(8'hAA);
    strobe(8'h80);
    strobe(8'hAA);
    strobe(8'hAA);
    chk("eqthr.alarm", int'(alarm), 0);
    strobe(8'hAA);
    chk("eqthr.late_rise", int'(alarm), 1);
    chk("eqthr.count", int'(event_count), 2);
    repeat (3) strobe(8'h00);

    // Inverted thresholds.
    @(negedge clk);
    thr_lo = 8'h90;
    repeat (5) strobe(8'hFF);
    chk("cfg.err", int'(cfg_err), 1);
    chk("cfg.alarm", int'(alarm), 0);
    thr_lo = 8'h40;
    @(negedge clk);
    chk("cfg.cleared", int'(cfg_err), 0);

    // Saturation of the event counter.
    repeat (260) episode();
    chk("sat.count", int'(event_count), 8'hFF);

    // Clear during alarm beats a simultaneous strobe.
    repeat (3) strobe(8'hAA);
    @(negedge clk);
    clear     = 1'b1;
    avg_valid = 1'b1;
    avg_in    = 8'hC0;
    @(negedge clk);
    clear     = 1'b0;
    avg_valid = 1'b0;
    chk("clear.alarm", int'(alarm), 0);
    chk("clear.count", int'(event_count), 0);
    chk("clear.peak", int'(peak), 0);
    chk("clear.nofall", int'(fall_pulse), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        thr_hi = 8'($urandom_range(8'h50, 8'hC0));
        thr_lo = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(int'(thr_hi) + 1, 255))
                                             : 8'($urandom_range(8'h10, int'(thr_hi)));
      end
      avg_valid = ($urandom_range(0, 3) != 0);
      avg_in    = 8'($urandom_range(0, 255));
      clear     = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    clear     = 1'b0;
    avg_valid = 1'b0;
    thr_hi    = 8'h80;
    thr_lo    = 8'h40;

    // Async reset while arming, with nonzero count/peak beforehand.
    @(negedge clk);
    episode();
    strobe(8'hAA);
    strobe(8'hAA);
    chk("prereset.count", int'(event_count != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.alarm", int'(alarm), 0);
    chk("areset.count", int'(event_count), 0);
    chk("areset.peak", int'(peak), 0);
    chk("areset.flags", int'({rise_pulse, fall_pulse, cfg_err}), 0);
    #20 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
